// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums, plus the
// bit positions of the FLAGS output.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpInv = 3'd0,
    OpAdd = 3'd1,
    OpSub = 3'd2,
    OpAnd = 3'd3,
    OpOr  = 3'd4,
    OpXor = 3'd5,
    OpSll = 3'd6,
    OpSrl = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } alu_state_e;

  localparam logic [1:0] FLAG_N = 2'd3;
  localparam logic [1:0] FLAG_Z = 2'd2;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_V = 2'd0;

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative one-bit-per-cycle shifter with down-counter. Outputs show the value
// after the current step so the owner can capture the final result on the last step.
module alu_iter_shifter
  import alu_seq_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           dir_i,
  input  logic [N-1:0]   data_i,
  input  logic [SHW-1:0] amt_i,
  output logic           last_o,
  output logic [N-1:0]   data_o,
  output logic           carry_o
);

  logic [N-1:0]   data_q, data_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    carry_o = 1'b0;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = amt_i;
      dir_d  = dir_i;
    end else if (step_i && (cnt_q != '0)) begin
      // dir_q: 1 = logical right, 0 = logical left; carry is the bit falling off
      if (dir_q) begin
        data_d  = {1'b0, data_q[N-1:1]};
        carry_o = data_q[0];
      end else begin
        data_d  = {data_q[N-2:0], 1'b0};
        carry_o = data_q[N-1];
      end
      cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
    end
  end

  assign last_o = step_i && (cnt_q == SHW'(1));
  assign data_o = data_d;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes; shifts take one cycle per bit.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   UC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] RESULT,
  output logic [3:0]   FLAGS,
  output logic         busy
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic         clr_sticky,
  output logic         sticky_ovf
`endif
);

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  alu_state_e     state_q;
  logic           out_valid_q, busy_q;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;

  alu_op_e        op_in;
  logic           xfer_in, xfer_out;
  logic [N:0]     add_w, sub_w;
  logic           b_in_range, is_shift, start_shift;
  logic [SHW-1:0] sh_amt;
  logic [N-1:0]   imm_res;
  logic           imm_c, imm_v;
  logic [3:0]     imm_flags;

  logic           sh_load, sh_step, sh_dir, sh_last, sh_carry;
  logic [N-1:0]   sh_res;

  assign op_in    = alu_op_e'(UC);
  assign in_ready = (state_q == StIdle) && !rst;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid_q && out_ready;

  assign add_w = {1'b0, A} + {1'b0, B};
  // Carry-out of A + ~B + 1 is the not-borrow, i.e. A >= B unsigned
  assign sub_w = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};

  assign b_in_range  = (B < N'(N));
  assign sh_amt      = B[SHW-1:0];
  assign is_shift    = (op_in == OpSll) || (op_in == OpSrl);
  assign start_shift = is_shift && b_in_range && (sh_amt != '0);

  always_comb begin
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (op_in)
      OpAdd: begin
        imm_res = add_w[N-1:0];
        imm_c   = add_w[N];
        imm_v   = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      OpSub: begin
        imm_res = sub_w[N-1:0];
        imm_c   = sub_w[N];
        imm_v   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      OpAnd:        imm_res = A & B;
      OpOr:         imm_res = A | B;
      OpXor:        imm_res = A ^ B;
      // Only the zero-amount and out-of-range cases finish here
      OpSll, OpSrl: imm_res = b_in_range ? A : '0;
      default:      imm_res = '0;
    endcase
    imm_flags = (op_in == OpInv) ? 4'b0000
                                 : pack_flags(imm_res[N-1], imm_res == '0, imm_c, imm_v);
  end

  assign sh_load = xfer_in && start_shift;
  assign sh_step = (state_q == StShift);
  assign sh_dir  = (op_in == OpSrl);

  alu_iter_shifter #(
    .N   (N),
    .SHW (SHW)
  ) u_shifter (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (sh_load),
    .step_i  (sh_step),
    .dir_i   (sh_dir),
    .data_i  (A),
    .amt_i   (sh_amt),
    .last_o  (sh_last),
    .data_o  (sh_res),
    .carry_o (sh_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (xfer_in) begin
            busy_q <= 1'b1;
            if (start_shift) begin
              state_q <= StShift;
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              result_q    <= imm_res;
              flags_q     <= imm_flags;
            end
          end
        end
        StShift: begin
          if (sh_last) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            result_q    <= sh_res;
            flags_q     <= pack_flags(sh_res[N-1], sh_res == '0, sh_carry, 1'b0);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign RESULT    = result_q;
  assign FLAGS     = flags_q;
  assign busy      = busy_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, arith_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      if (xfer_in) begin
        arith_q <= (op_in == OpAdd) || (op_in == OpSub);
      end
      // Set has priority over clear
      if (xfer_out && arith_q && flags_q[FLAG_V]) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (N=32): vector table through a result
// scoreboard, plus hand sequences for backpressure, mid-shift reset and sticky overflow.
module tb_alu_seq_unit;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [N-1:0]  a, b;
  logic [2:0]    uc;
  logic          out_valid, out_ready;
  logic [N-1:0]  result;
  logic [3:0]    flags;
  logic          busy;
`ifdef ALU_STICKY_OVF_EN
  logic          clr_sticky, sticky_ovf;
  logic          clr_at_out;
`endif

  always #5 clk = ~clk;

  alu_seq_unit #(
    .N (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a),
    .B          (b),
    .UC         (uc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RESULT     (result),
    .FLAGS      (flags),
    .busy       (busy)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
`endif
  );

  typedef struct {
    logic [2:0]   uc;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [3:0]   flg;
    int           lat;
  } vec_t;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flg;
    int           lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference for add/sub/xor using wide signed arithmetic
  task automatic model(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                       output logic [N-1:0] r, output logic [3:0] f);
    longint unsigned u;
    longint          s;
    logic            c, v;
    c = 1'b0;
    v = 1'b0;
    if (op == 3'd1) begin
      u = longint'(x) + longint'(y);
      r = u[N-1:0];
      c = u[N];
      s = longint'($signed(x)) + longint'($signed(y));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == 3'd2) begin
      r = x - y;
      c = (x >= y);
      s = longint'($signed(x)) - longint'($signed(y));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      r = x ^ y;
    end
    f = {r[N-1], (r == '0), c, v};
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] r, input logic [3:0] f, input int lat);
    vec_t v;
    v.uc = op; v.a = x; v.b = y; v.res = r; v.flg = f; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op, wait for its result, compare against the scoreboard head,
  // optionally hold out_ready low for 'hold' cycles while the result is presented.
  task automatic do_op(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] er, input logic [3:0] ef, input int el,
                       input int hold);
    exp_t         e;
    exp_t         got;
    int           lat;
    logic [N-1:0] r0;
    logic [3:0]   f0;
    e.res = er; e.flg = ef; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    uc = op; a = x; b = y; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands to show they were captured
    a = $urandom; b = $urandom; uc = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("result", result, got.res);
    check("flags", {28'd0, flags}, {28'd0, got.flg});
    check("latency", lat, got.lat);
    r0 = result;
    f0 = flags;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      uc = 3'd1; a = 32'h1234; b = 32'h1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_result", result, r0);
      check("hold_flags", {28'd0, flags}, {28'd0, f0});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = clr_at_out;
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [N-1:0] rr;
    logic [3:0]   ff;
    logic [N-1:0] xr, yr;
    logic [2:0]   opr;
    int           seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; uc = '0;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0; clr_at_out = 1'b0;
`endif

    //      uc    A             B             RESULT        FLAGS    lat
    add_vec(3'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1);
    add_vec(3'd2, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1);
    add_vec(3'd2, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1);
    add_vec(3'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1);
    add_vec(3'd1, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111, 1);
    add_vec(3'd2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1);
    add_vec(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1);
    add_vec(3'd4, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 1);
    add_vec(3'd4, 32'h00F00000, 32'h0000000F, 32'h00F0000F, 4'b0000, 1);
    add_vec(3'd5, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b0100, 1);
    add_vec(3'd0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0000, 1);
    add_vec(3'd6, 32'h80000001, 32'h00000004, 32'h00000010, 4'b0000, 5);
    add_vec(3'd6, 32'h80000001, 32'd40,       32'h00000000, 4'b0100, 1);
    add_vec(3'd6, 32'hFFFFFFFF, 32'd32,       32'h00000000, 4'b0100, 1);
    add_vec(3'd6, 32'h00000001, 32'd0,        32'h00000001, 4'b0000, 1);
    add_vec(3'd6, 32'h40000001, 32'd2,        32'h00000004, 4'b0001 << 1, 3);
    add_vec(3'd7, 32'h80000000, 32'd31,       32'h00000001, 4'b0000, 32);
    add_vec(3'd7, 32'hFFFFFFFF, 32'd31,       32'h00000001, 4'b0010, 32);
    add_vec(3'd7, 32'h80000000, 32'd1,        32'h40000000, 4'b0000, 2);
    for (int i = 0; i < 4; i++) begin
      opr = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd2 : 3'd5);
      xr = $urandom; yr = $urandom;
      model(opr, xr, yr, rr, ff);
      add_vec(opr, xr, yr, rr, ff, 1);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].uc, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat, 0);
    end

    // Backpressure: srl 3 by 1, consumer stalls 3 cycles
    do_op(3'd7, 32'h3, 32'h1, 32'h1, 4'b0010, 2, 3);

    // Reset in the middle of a long shift aborts it
    @(negedge clk);
    uc = 3'd6; a = 32'h1; b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("shift_busy", {31'd0, busy}, 32'd1);
    check("shift_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1;
    end
    check("abort_no_result", seen, 32'd0);
    do_op(3'd1, 32'd100, 32'd23, 32'd123, 4'b0000, 1, 0);

`ifdef ALU_STICKY_OVF_EN
    check("sticky_init", {31'd0, sticky_ovf}, 32'd0);
    do_op(3'd1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1, 0);
    check("sticky_set", {31'd0, sticky_ovf}, 32'd1);
    do_op(3'd1, 32'h1, 32'h1, 32'h2, 4'b0000, 1, 0);
    check("sticky_hold", {31'd0, sticky_ovf}, 32'd1);
    clr_at_out = 1'b1;
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h0, 4'b0111, 1, 0);
    clr_at_out = 1'b0;
    check("sticky_set_wins", {31'd0, sticky_ovf}, 32'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    check("sticky_clear", {31'd0, sticky_ovf}, 32'd0);
`endif

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
